// File: rtl/pipe_seq_pkg.sv
// Shared state encoding and decode codes for the pipeline sequencer.
package pipe_seq_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } seq_state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JR  = 2'b10;
    localparam logic [1:0] PCSEL_J   = 2'b11;

    localparam logic [1:0] MDOP_NONE = 2'b00;
    localparam logic [1:0] MDOP_MUL  = 2'b01;
    localparam logic [1:0] MDOP_DIV  = 2'b10;

endpackage

// File: rtl/pipe_seq_md_timer.sv
// Loadable down-counter timing the MUL/DIV wait; holds at zero rather than wrapping.
module pipe_seq_md_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset_0) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline flow controller: load-use stalls, redirect squash and MUL/DIV sequencing.
// Optional PIPE_SEQ_STATS_EN adds saturating stall_cycles / flush_count outputs.
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rw_ex,
    input  logic        wreg_ex,
    input  logic        m2reg_ex,
    input  logic [1:0]  pc_select,
    input  logic [1:0]  md_op_id,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        md_start,
    output logic        md_busy,
`ifdef PIPE_SEQ_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        md_done
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             load_use;
    logic             md_mul;
    logic             md_req;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_load_val;

    assign load_use = wreg_ex && m2reg_ex && (rw_ex != 5'd0) &&
                      ((rw_ex == rs_id) || (rw_ex == rt_id));
    assign md_mul   = (md_op_id == MDOP_MUL);
    assign md_req   = md_mul || (md_op_id == MDOP_DIV);

    // Counter holds remaining wait cycles after the current one.
    assign tmr_load_val = md_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    pipe_seq_md_timer #(
        .CNT_W (CNT_W)
    ) u_md_timer (
        .clock    (clock),
        .reset_0  (reset_0),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset_0) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        case (state_q)
            RUN: begin
                if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (md_req) begin
                    md_start   = 1'b1;
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    tmr_load   = 1'b1;
                    state_d    = MD_WAIT;
                end else if (pc_select != PCSEL_SEQ) begin
                    ifid_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (!tmr_zero) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    tmr_dec    = 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef PIPE_SEQ_STATS_EN
    // Saturating event counters for performance monitoring.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
